// File: rtl/nibble_link_pkg.sv
// Shared types and helpers for the nibble link scheduler.
package nibble_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam int DEF_NIB_W = 4;

  function automatic int beats(input int data_w, input int nib_w);
    return data_w / nib_w;
  endfunction

endpackage

// File: rtl/nibble_link_ctrl_rr_arb2.sv
// Two-way round-robin grant; the pointer register lives in the parent.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic rr_ptr_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  assign gnt0_o = valid0_i && (!valid1_i || !rr_ptr_i);
  assign gnt1_o = valid1_i && (!valid0_i || rr_ptr_i);

endmodule

// File: rtl/nibble_link_ctrl.sv
// Two-requester word scheduler that serialises words MS-nibble first onto a
// narrow link. Optional trailing parity beat: define NIBBLE_LINK_PARITY_EN.
//
// state | meaning
// IDLE  | no word held; grant a requester and latch its word
// SEND  | data beats of the latched word on the link
// PAR   | trailing parity beat (parity build only)
module nibble_link_ctrl
  import nibble_link_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NIB_W  = DEF_NIB_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              link_valid,
  input  logic              link_ready,
  output logic [NIB_W-1:0]  link_nib,
  output logic              link_last,
  output logic              link_src,
  output logic              link_par,
  output logic [CNT_W-1:0]  xfer_cnt
);

  localparam int BEATS  = beats(DATA_W, NIB_W);
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_SEND = SEND;
  localparam logic [1:0] S_PAR  = PAR;

`ifdef NIBBLE_LINK_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              src_q, src_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic gnt0, gnt1, done;
  logic [NIB_W-1:0] nib_sel;

  rr_arb2 u_arb (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .rr_ptr_i (rr_ptr_q),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1)
  );

  // Ready is gated by rst so every output reads 0 while reset is held.
  assign req0_ready = (state_q == S_IDLE) && !rst && gnt0;
  assign req1_ready = (state_q == S_IDLE) && !rst && gnt1;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    beat_d   = beat_q;
    rr_ptr_d = rr_ptr_q;
    src_d    = src_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt0 || gnt1) begin
          shadow_d = gnt1 ? req1_data : req0_data;
          src_d    = gnt1;
          beat_d   = LAST_BEAT;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (link_ready) begin
          if (beat_q != '0) beat_d = beat_q - 1'b1;
          else if (PAR_EN)  state_d = S_PAR;
          else              done = 1'b1;
        end
      end
      S_PAR: begin
        if (link_ready) done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (done) begin
      state_d  = S_IDLE;
      rr_ptr_d = ~src_q;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      beat_q   <= '0;
      rr_ptr_q <= 1'b0;
      src_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      beat_q   <= beat_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    nib_sel = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (beat_q == BEAT_W'(i)) nib_sel = shadow_q[i*NIB_W +: NIB_W];
    end
  end

  assign link_valid = (state_q == S_SEND) || (state_q == S_PAR);
  assign link_nib   = (state_q == S_SEND) ? nib_sel : '0;
  assign link_last  = ((state_q == S_SEND) && (beat_q == '0) && !PAR_EN) ||
                      (state_q == S_PAR);
  assign link_par   = PAR_EN && (state_q == S_PAR) && (^shadow_q);
  assign link_src   = src_q;
  assign xfer_cnt   = cnt_q;

endmodule

// File: tb/tb_nibble_link_ctrl.sv
// Self-checking bench for nibble_link_ctrl (default 8-bit word, 4-bit beats).
module tb_nibble_link_ctrl;

`ifdef NIBBLE_LINK_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 2 + PAR;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, link_ready = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready, link_valid, link_last, link_src, link_par;
  logic [3:0] link_nib;
  logic [7:0] xfer_cnt;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [3:0] nib;
    logic       last;
    logic       src;
    logic       par;
  } beat_t;

  nibble_link_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .link_valid(link_valid), .link_ready(link_ready), .link_nib(link_nib),
    .link_last(link_last), .link_src(link_src), .link_par(link_par),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // Beat b of word d: high nibble, low nibble, then (parity build) a zero nibble.
  function automatic logic [3:0] exp_nib(input logic [7:0] d, input int b);
    int v;
    if (b == 0) v = int'(d) / 16;
    else if (b == 1) v = int'(d) % 16;
    else v = 0;
    return 4'(v);
  endfunction

  function automatic logic exp_par(input logic [7:0] d, input int b);
    int ones = 0;
    if (PAR == 0 || b != 2) return 1'b0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return logic'(ones % 2);
  endfunction

  task automatic step(input logic v0, input logic [7:0] d0, input logic v1,
                      input logic [7:0] d1, input logic rdy);
    @(negedge clk);
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    link_ready = rdy;
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; link_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h5A; link_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", req0_ready); end
    total++; if (link_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", link_valid); end
    total++; if (link_nib !== 4'h0) begin bad++; $display("FAIL reset_nib got %h want 0", link_nib); end
    total++; if ({link_last, link_src, link_par} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {link_last, link_src, link_par}); end
    total++; if (xfer_cnt !== 8'h00) begin bad++; $display("FAIL reset_cnt got %0d want 0", xfer_cnt); end
    req0_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    reset_dut();
    step(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL single_grant got %b want 10", {req0_ready, req1_ready}); end
    total++; if (link_valid !== 1'b0) begin bad++; $display("FAIL single_idle_valid got %b want 0", link_valid); end
    for (int b = 0; b < NB; b++) begin
      step(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
      total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL single_ready_pulse b%0d got %b want 0", b, req0_ready); end
      total++; if (link_valid !== 1'b1) begin bad++; $display("FAIL single_valid b%0d got %b want 1", b, link_valid); end
      total++; if (link_nib !== exp_nib(8'hA5, b)) begin bad++; $display("FAIL single_nib b%0d got %h want %h", b, link_nib, exp_nib(8'hA5, b)); end
      total++; if (link_last !== logic'(b == NB - 1)) begin bad++; $display("FAIL single_last b%0d got %b want %b", b, link_last, b == NB - 1); end
      total++; if (link_src !== 1'b0) begin bad++; $display("FAIL single_src b%0d got %b want 0", b, link_src); end
      total++; if (link_par !== exp_par(8'hA5, b)) begin bad++; $display("FAIL single_par b%0d got %b want %b", b, link_par, exp_par(8'hA5, b)); end
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    total++; if (link_valid !== 1'b0) begin bad++; $display("FAIL single_gap got %b want 0", link_valid); end
    total++; if (xfer_cnt !== 8'd1) begin bad++; $display("FAIL single_cnt got %0d want 1", xfer_cnt); end
  endtask

  task automatic test_round_robin();
    logic [7:0] w;
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      w = (k % 2 == 1) ? 8'h34 : 8'h12;
      step(1'b1, 8'h12, 1'b1, 8'h34, 1'b1);
      total++; if ({req1_ready, req0_ready} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_grant w%0d got r1r0=%b want src %0d", k, {req1_ready, req0_ready}, k % 2); end
      for (int b = 0; b < NB; b++) begin
        step(1'b1, 8'h12, 1'b1, 8'h34, 1'b1);
        total++; if (link_nib !== exp_nib(w, b)) begin bad++; $display("FAIL rr_nib w%0d b%0d got %h want %h", k, b, link_nib, exp_nib(w, b)); end
        total++; if (link_src !== logic'(k % 2)) begin bad++; $display("FAIL rr_src w%0d got %b want %0d", k, link_src, k % 2); end
        total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL rr_busy_ready w%0d got %b want 00", k, {req0_ready, req1_ready}); end
      end
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    total++; if (xfer_cnt !== 8'd4) begin bad++; $display("FAIL rr_cnt got %0d want 4", xfer_cnt); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    step(1'b1, 8'hC3, 1'b0, 8'h00, 1'b0);
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL bp_grant got %b want 1", req0_ready); end
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 8'hC3, 1'b0, 8'h00, 1'b0);
      total++; if ({link_valid, link_nib, link_last} !== {1'b1, 4'hC, 1'b0}) begin bad++; $display("FAIL bp_hold c%0d got v%b n%h l%b want v1 nC l0", c, link_valid, link_nib, link_last); end
      total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL bp_ready c%0d got %b want 0", c, req0_ready); end
    end
    for (int b = 0; b < NB; b++) begin
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      total++; if (link_nib !== exp_nib(8'hC3, b)) begin bad++; $display("FAIL bp_nib b%0d got %h want %h", b, link_nib, exp_nib(8'hC3, b)); end
      total++; if (link_last !== logic'(b == NB - 1)) begin bad++; $display("FAIL bp_last b%0d got %b want %b", b, link_last, b == NB - 1); end
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    total++; if (xfer_cnt !== 8'd1) begin bad++; $display("FAIL bp_cnt got %0d want 1", xfer_cnt); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    step(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    for (int b = 0; b < NB; b++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hF0, 1'b0, 8'h00, 1'b1);
    total++; if (xfer_cnt !== 8'd1) begin bad++; $display("FAIL ar_pre_cnt got %0d want 1", xfer_cnt); end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    total++; if (link_nib !== 4'hF) begin bad++; $display("FAIL ar_pre_nib got %h want F", link_nib); end
    #1 rst = 1'b1;
    #1;
    total++; if ({link_valid, link_nib, link_last, link_src} !== 7'd0) begin bad++; $display("FAIL ar_outputs got v%b n%h l%b s%b want all 0", link_valid, link_nib, link_last, link_src); end
    total++; if (xfer_cnt !== 8'd0) begin bad++; $display("FAIL ar_cnt got %0d want 0", xfer_cnt); end
    rst = 1'b0;
    step(1'b1, 8'h66, 1'b1, 8'h0F, 1'b1);
    total++; if ({req1_ready, req0_ready} !== 2'b01) begin bad++; $display("FAIL ar_rr_ptr got r1r0=%b want 01", {req1_ready, req0_ready}); end
    req0_valid = 1'b0;
    #1;
    total++; if ({req1_ready, req0_ready} !== 2'b10) begin bad++; $display("FAIL ar_req1_grant got r1r0=%b want 10", {req1_ready, req0_ready}); end
    for (int b = 0; b < NB; b++) begin
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      total++; if ({link_nib, link_src} !== {exp_nib(8'h0F, b), 1'b1}) begin bad++; $display("FAIL ar_post b%0d got n%h s%b want n%h s1", b, link_nib, link_src, exp_nib(8'h0F, b)); end
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    total++; if (xfer_cnt !== 8'd1) begin bad++; $display("FAIL ar_post_cnt got %0d want 1", xfer_cnt); end
  endtask

  task automatic test_wrap();
    reset_dut();
    for (int k = 0; k < 256; k++) begin
      step(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b1);
      if (k == 255) begin
        total++; if (xfer_cnt !== 8'd255) begin bad++; $display("FAIL wrap_255 got %0d want 255", xfer_cnt); end
      end
      for (int b = 0; b < NB; b++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    total++; if (xfer_cnt !== 8'd0) begin bad++; $display("FAIL wrap_zero got %0d want 0", xfer_cnt); end
  endtask

  task automatic test_parity();
    logic [7:0] words [2];
    words[0] = 8'h07;
    words[1] = 8'h03;
    reset_dut();
    for (int k = 0; k < 2; k++) begin
      step(1'b1, words[k], 1'b0, 8'h00, 1'b1);
      for (int b = 0; b < NB; b++) begin
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        total++; if ({link_nib, link_last, link_par} !== {exp_nib(words[k], b), logic'(b == NB - 1), exp_par(words[k], b)}) begin
          bad++; $display("FAIL par_beat w%h b%0d got n%h l%b p%b want n%h l%b p%b", words[k], b, link_nib, link_last, link_par,
                          exp_nib(words[k], b), b == NB - 1, exp_par(words[k], b));
        end
      end
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    total++; if (xfer_cnt !== 8'd2) begin bad++; $display("FAIL par_cnt got %0d want 2", xfer_cnt); end
  endtask

  // Reference: a word is a list of beats; owner alternates after each completed word.
  task automatic test_random();
    beat_t      q[$];
    beat_t      bt;
    logic       busy = 1'b0, pref = 1'b0, g0, g1, v0, v1, rdy;
    logic [7:0] d0, d1, word;
    logic [7:0] mcnt = '0;
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      v0 = ($urandom_range(0, 2) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      step(v0, d0, v1, d1, rdy);
      total++; if (xfer_cnt !== mcnt) begin bad++; $display("FAIL rnd_cnt c%0d got %0d want %0d", c, xfer_cnt, mcnt); end
      if (!busy) begin
        g0 = v0 && (!v1 || pref == 1'b0);
        g1 = v1 && (!v0 || pref == 1'b1);
        total++; if ({link_valid, req0_ready, req1_ready} !== {1'b0, g0, g1}) begin bad++; $display("FAIL rnd_grant c%0d got v%b r0%b r1%b want v0 r0%b r1%b", c, link_valid, req0_ready, req1_ready, g0, g1); end
        if (g0 || g1) begin
          word = g1 ? d1 : d0;
          for (int b = 0; b < NB; b++) q.push_back('{exp_nib(word, b), logic'(b == NB - 1), g1, exp_par(word, b)});
          busy = 1'b1;
        end
      end else begin
        bt = q[0];
        total++; if ({link_valid, req0_ready, req1_ready} !== 3'b100) begin bad++; $display("FAIL rnd_busy c%0d got v%b r0%b r1%b want v1 r00 r10", c, link_valid, req0_ready, req1_ready); end
        total++; if ({link_nib, link_last, link_src, link_par} !== bt) begin bad++; $display("FAIL rnd_beat c%0d got n%h l%b s%b p%b want n%h l%b s%b p%b", c, link_nib, link_last, link_src, link_par, bt.nib, bt.last, bt.src, bt.par); end
        if (rdy) begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            busy = 1'b0;
            mcnt = mcnt + 8'd1;
            pref = ~bt.src;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    test_parity();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
